// File: rtl/clk_gate_pkg.sv
// Shared types and widths for the clock-gate enable controller.
package clk_gate_pkg;

  localparam int WAKE_W = 4;
  localparam int IDLE_W = 8;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    IDLE = 2'd3
  } cg_state_t;

endpackage

// File: rtl/cg_down_counter.sv
// Loadable down counter with zero flag; the decrement is ignored at zero,
// so the count never wraps.
module cg_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller: OFF -> WAKE -> ON -> IDLE -> OFF.
// A request from OFF is granted WAKE_CYCLES+1 cycles after it is sampled; from IDLE, after 1 cycle.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               force_on,
  output logic               gate_en,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy
);

  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(IDLE_CYCLES - 1);

  cg_state_t state, next_state;
  logic      any_req;
  logic      wake_zero, idle_zero;
  logic      wake_load, wake_dec, idle_load, idle_dec;

  assign any_req = (|req) | force_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      OFF:     if (any_req) next_state = WAKE;
      WAKE:    if (wake_zero) next_state = ON;
      ON:      if (!any_req) next_state = IDLE;
      IDLE: begin
        if (any_req) begin
          next_state = ON;
        end else if (idle_zero) begin
          next_state = OFF;
        end
      end
      default: next_state = OFF;
    endcase
  end

  always_comb begin
    gnt  = '0;
    busy = (state != OFF);
    if (state == ON) begin
      gnt = req;
    end
  end

  // Registered from next_state so the clock-gate cell never sees an input glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_en <= 1'b0;
    end else begin
      gate_en <= (next_state != OFF);
    end
  end

  assign wake_load = (state == OFF) && any_req;
  assign wake_dec  = (state == WAKE);
  assign idle_load = (state == ON) && !any_req;
  assign idle_dec  = (state == IDLE) && !any_req;

  cg_down_counter #(.W(WAKE_W)) u_wake_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (wake_load),
    .load_val (WAKE_LOAD),
    .dec      (wake_dec),
    .zero     (wake_zero)
  );

  cg_down_counter #(.W(IDLE_W)) u_idle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (idle_load),
    .load_val (IDLE_LOAD),
    .dec      (idle_dec),
    .zero     (idle_zero)
  );

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with default parameters (WAKE=2, IDLE=8).
module tb_clk_gate_ctrl;
  import clk_gate_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       force_on;
  logic       gate_en;
  logic [3:0] gnt;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  clk_gate_ctrl #(.NUM_REQ(4), .WAKE_CYCLES(2), .IDLE_CYCLES(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .force_on (force_on),
    .gate_en  (gate_en),
    .gnt      (gnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n_wake, n_on, n_idle;
    logic [3:0] gnt_seen;

    rst = 1'b1; req = 4'b0000; force_on = 1'b0;
    tick(3);
    check("rst_gate_en", gate_en, 0);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dut.state, OFF);

    // Wake from OFF: gate_en at cycle 1, gnt at cycle 3.
    rst = 1'b0; req = 4'b0001; #1;
    check("c0_gate_en", gate_en, 0);
    check("c0_gnt", gnt, 0);
    tick();
    check("c1_gate_en", gate_en, 1);
    check("c1_busy", busy, 1);
    check("c1_gnt", gnt, 0);
    tick();
    check("c2_gnt", gnt, 0);
    check("c2_busy", busy, 1);
    tick();
    check("c3_gnt", gnt, 4'b0001);

    // Drop in ON: gnt falls at once, 8 IDLE cycles, then OFF.
    req = 4'b0000; #1;
    check("drop_gnt_comb", gnt, 0);
    check("drop_gate_en", gate_en, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("idle%0d_gate_en", i), gate_en, 1);
    end
    tick();
    check("idle_end_gate_en", gate_en, 0);
    check("idle_end_busy", busy, 0);

    // Re-request from IDLE at count 3.
    req = 4'b0001; tick(3);
    req = 4'b0000; tick();
    tick(4);
    check("idle_cnt3_state", dut.state, IDLE);
    req = 4'b0100; tick();
    check("idle_rereq_gnt", gnt, 4'b0100);
    check("idle_rereq_state", dut.state, ON);
    req = 4'b0000; tick();
    tick(7);
    check("idle_restart_gate_en", gate_en, 1);
    tick();
    check("idle_restart_off", gate_en, 0);

    // Simultaneous requests, then force_on with no requests.
    req = 4'b1010; tick(2);
    check("multi_c2_gnt", gnt, 0);
    tick();
    check("multi_c3_gnt", gnt, 4'b1010);
    force_on = 1'b1; req = 4'b0000; #1;
    check("force_gnt", gnt, 0);
    tick(20);
    check("force_state", dut.state, ON);
    check("force_gate_en", gate_en, 1);
    check("force_gnt_late", gnt, 0);
    force_on = 1'b0; rst = 1'b1; tick();
    check("rst_on_state", dut.state, OFF);
    check("rst_on_gate_en", gate_en, 0);
    rst = 1'b0;

    // Reset during WAKE and during ON, request held throughout.
    req = 4'b0001; tick();
    check("w_state", dut.state, WAKE);
    rst = 1'b1; tick();
    check("rst_wake_state", dut.state, OFF);
    check("rst_wake_gate_en", gate_en, 0);
    rst = 1'b0; tick(3);
    check("rewake1_gnt", gnt, 4'b0001);
    rst = 1'b1; tick();
    check("rst_on_gnt", gnt, 0);
    check("rst_on2_gate_en", gate_en, 0);
    rst = 1'b0; tick(2);
    check("rewake2_c2_gnt", gnt, 0);
    tick();
    check("rewake2_c3_gnt", gnt, 4'b0001);

    // Requests joining during WAKE share the same ON entry.
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    check("join_state", dut.state, WAKE);
    req = 4'b0011; tick();
    check("join_c2_gnt", gnt, 0);
    tick();
    check("join_gnt", gnt, 4'b0011);

    // One-cycle pulse from OFF: WAKE(2), ON(1), IDLE(8), OFF, no gnt.
    rst = 1'b1; req = 4'b0000; tick(); rst = 1'b0;
    req = 4'b0001; tick();
    req = 4'b0000;
    n_wake = 0; n_on = 0; n_idle = 0; gnt_seen = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      #1;
      gnt_seen |= gnt;
      if (dut.state == WAKE) n_wake++;
      if (dut.state == ON)   n_on++;
      if (dut.state == IDLE) n_idle++;
      tick();
    end
    check("pulse_wake_cycles", n_wake, 2);
    check("pulse_on_cycles", n_on, 1);
    check("pulse_idle_cycles", n_idle, 8);
    check("pulse_gnt_never", gnt_seen, 0);
    check("pulse_final_state", dut.state, OFF);
    check("pulse_final_gate_en", gate_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
- REQ-001: Parameter NUM_REQ, default 4: number of requesters sharing the gated clock domain.
- REQ-002: Parameter WAKE_CYCLES, default 2: cycles from gate_en rising to grant; legal range 1..15.
- REQ-003: Parameter IDLE_CYCLES, default 8: cycles with no request before gate_en falls; legal range 1..255.
- REQ-004: Port clk, input, 1: the single clock; every flop samples on its rising edge.
- REQ-005: Port rst, input, 1: reset; synchronous and active-high.
- REQ-006: Port req, input, NUM_REQ: per-requester level request for the gated clock; held until the requester's work completes.
- REQ-007: Port force_on, input, 1: software override; keeps the gate open while high.
- REQ-008: Port gate_en, output, 1: registered enable, intended as the enable input of an AND-type clock-gate cell.
- REQ-009: Port gnt, output, NUM_REQ: per-requester acknowledge that the gated clock is running.
- REQ-010: Port busy, output, 1: high whenever state is not OFF.

Function
- REQ-011: The controller SHALL implement exactly four states: OFF, WAKE, ON and IDLE.
- REQ-012: Define any_req = (|req) | force_on.
- REQ-013: OFF: gate_en=0 and gnt=0; on any_req, next state SHALL be WAKE, wake counter loads WAKE_CYCLES-1, and gate_en=1 from the next cycle.
- REQ-014: WAKE: gate_en=1 and gnt=0; counter decrements each cycle; at 0, next state SHALL be ON, regardless of any_req.
- REQ-015: ON: gnt[i] SHALL equal req[i], combinationally; when any_req=0, next state SHALL be IDLE and the idle counter loads IDLE_CYCLES-1.
- REQ-016: IDLE: gate_en=1 and gnt=0; if any_req=1, next state SHALL be ON, with no re-wake; otherwise the counter decrements; at 0 with any_req=0, next state SHALL be OFF and gate_en=0 from the next cycle.
- REQ-017: Latency: a request arriving in OFF SHALL see its gnt exactly WAKE_CYCLES+1 cycles after req is first sampled high.
- REQ-018: A request in IDLE SHALL see its gnt 1 cycle after it is sampled.
- REQ-019: Requests arriving during WAKE SHALL be served in the same ON entry; no extra wake.
- REQ-020: Every requester dropping during WAKE SHALL still complete WAKE, then pass through ON for one cycle to IDLE.
- REQ-021: Simultaneous requests SHALL be granted together; there is no arbitration priority, since the resource is shared.
- REQ-022: Counters SHALL be 4-bit (wake) and 8-bit (idle), unsigned; they never wrap, because they are only decremented while nonzero.
- REQ-023: gate_en SHALL be driven directly from a flop, with no combinational path from inputs.

Reset
- REQ-024: While rst is sampled high: state=OFF, both counters=0, gate_en=0, gnt=0, busy=0.
- REQ-025: rst asserted mid-operation (WAKE, ON or IDLE) SHALL force OFF at the next edge; gnt drops combinationally with the state.
- REQ-026: The first cycle after rst falls SHALL evaluate as OFF; a request already held high then enters WAKE.

Structure
- REQ-027: Package clk_gate_pkg SHALL hold the state enum (OFF, WAKE, ON, IDLE) and the counter width constants WAKE_W=4 and IDLE_W=8.
- REQ-028: One sub-module, cg_down_counter, SHALL be used: load, decrement and zero flag, parameterized width; it is instantiated for the wake counter and for the idle counter.
- REQ-029: The gating cell itself SHALL be instantiated outside this block, together with its enable latch.

Verification
- REQ-030: rst=1 for 3 cycles, then req=0001 held -> gate_en rises at cycle 1; gnt[0] rises at cycle 3 (WAKE_CYCLES=2); busy=1 throughout.
- REQ-031: In ON with req=0001, drop req and hold 0 -> gnt=0 immediately; gate_en stays high 8 cycles, then falls; busy falls with it.
- REQ-032: In IDLE at counter value 3, assert req=0100 -> gnt[2]=1 on the next cycle, with no WAKE visited; dropping req restarts the idle count at 7.
- REQ-033: From OFF, set req=1010 in the same cycle -> gnt=1010 together after 3 cycles; then force_on=1 with req=0 -> state stays ON indefinitely and gnt=0.
- REQ-034: Assert rst for 1 cycle during WAKE and again during ON -> next cycle state=OFF, gate_en=0, gnt=0; with req still high afterward, a full re-wake occurs (gnt after 3 cycles).
- REQ-035: From OFF, pulse req=0001 for 1 cycle -> sequence WAKE(2), ON(1), IDLE(8), OFF; gnt is never asserted.
